guess_evaluator: RTL and testbench
==================================

GUESS_EVALUATOR -- requirements
Module: guess_evaluator

Interface
REQ-001 SHALL have parameter MAX_MISTAKES, default 6, meaning wrong guesses that end the game (legal 1..7).
REQ-002 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 SHALL have port nRst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port word  input  40  secret word, 5 uppercase ASCII chars, char0 in [39:32], char4 in [7:0].
REQ-005 SHALL have port word_load  input  1  one-cycle strobe: latch word, start new game.
REQ-006 SHALL have port guess  input  8  guessed ASCII character.
REQ-007 SHALL have port guess_valid  input  1  one-cycle strobe qualifying guess.
REQ-008 SHALL have port ready  output  1  high when a guess is accepted this cycle.
REQ-009 SHALL have port letter  output  8  last evaluated guess, uppercase ASCII.
REQ-010 SHALL have port indexCorrect  output  5  cumulative revealed mask, bit4 = char0, bit0 = char4.
REQ-011 SHALL have port correct  output  3  positions matched by last guess (0..5).
REQ-012 SHALL have port mistake  output  1  last evaluated guess was wrong.
REQ-013 SHALL have port numMistake  output  3  cumulative wrong guesses.
REQ-014 SHALL have port game_won  output  1  all five positions revealed.
REQ-015 SHALL have port game_lost  output  1  numMistake reached MAX_MISTAKES.

Function
REQ-016 SHALL implement FSM states IDLE, PLAY, EVAL, WON, LOST.
REQ-017 IDLE: ready=0; word_load -> PLAY, word latched internally, all game outputs cleared.
REQ-018 PLAY: ready=1; guess_valid with legal guess -> guess registered, -> EVAL.
REQ-019 Legal guess: 'A'..'Z' or 'a'..'z'; lowercase folded to uppercase; other codes ignored, state held, no output change.
REQ-020 EVAL (one cycle, ready=0): compare guess with all 5 latched chars in parallel; outputs update on the edge leaving EVAL, i.e. 2 edges after acceptance.
REQ-021 Hit: correct = popcount of match vector; indexCorrect |= match; mistake=0; letter=guess.
REQ-022 Miss: correct=0; mistake=1; numMistake+1 (saturating at 7); letter=guess.
REQ-023 After EVAL: indexCorrect==5'b11111 -> WON; else numMistake==MAX_MISTAKES -> LOST; else PLAY.
REQ-024 WON/LOST: game_won/game_lost held high, ready=0, guess_valid ignored, all other outputs frozen.
REQ-025 word_load in any state restarts game (-> PLAY, outputs cleared, new word latched); word_load beats guess_valid in the same cycle; word_load during EVAL discards the pending guess.
REQ-026 Latched word SHALL not follow word input except on word_load.
REQ-027 guess_valid while ready=0 SHALL be dropped, no queuing.

Reset
REQ-028 nRst high at a rising edge -> IDLE; letter=8'h00, indexCorrect=0, correct=0, mistake=0, numMistake=0, game_won=0, game_lost=0, ready=0, latched word=0.
REQ-029 Reset SHALL override word_load and guess_valid, including mid-EVAL.

Configuration
REQ-030 Macro REPEAT_FILTER_EN defined: 26-bit used-letter set, cleared on reset/word_load; guess of an already-used letter completes EVAL with correct=0, mistake=0, numMistake and indexCorrect unchanged, letter updated.
REQ-031 Macro REPEAT_FILTER_EN undefined: no set; repeated letter re-evaluated normally (repeated miss increments numMistake again, repeated hit rewrites the same mask bits).

Verification
REQ-032 Reset, word_load "APPLE", guess 'P' -> two edges later correct=2, indexCorrect=01100, mistake=0, letter=8'h50.
REQ-033 "APPLE", guess 'b' -> letter=8'h42, mistake=1, numMistake=1, correct=0.
REQ-034 "APPLE", guesses A,P,L,E -> indexCorrect=11111, game_won=1, ready=0; further guess_valid leaves outputs frozen.
REQ-035 "APPLE", MAX_MISTAKES=6, six distinct misses -> numMistake=6, game_lost=1; word_load then clears all outputs, ready=1.
REQ-036 Guess 'Z' twice: with REPEAT_FILTER_EN numMistake=1 after both; without, numMistake=2; guess 8'h31 ('1') -> no state change.
REQ-037 nRst pulsed during EVAL -> next cycle IDLE, all outputs zero; word_load with guess_valid same cycle -> guess discarded.

Source files
------------

// File: rtl/guess_evaluator.sv
// guess_evaluator: letter-guessing game evaluator for a 5-character secret word.
//
// A word_load strobe latches the secret word and starts a game. While playing,
// each legal guess (A-Z or a-z; lowercase folded to uppercase) is registered,
// compared against all five characters in one EVAL cycle, and the results
// appear on the outputs on the edge leaving EVAL. The game ends when every
// position is revealed (WON) or the mistake count reaches MAX_MISTAKES (LOST).
//
// Optional feature macro: REPEAT_FILTER_EN
//   When defined, a 26-bit set of already-guessed letters is kept. A repeated
//   letter is evaluated as neither hit nor miss; only 'letter' updates.
//
// Ports
//   clk          in   system clock, rising edge
//   nRst         in   synchronous reset, active HIGH despite the name
//   word[39:0]   in   secret word, char0 in [39:32] ... char4 in [7:0]
//   word_load    in   strobe: latch word, start a new game (any state)
//   guess[7:0]   in   guessed ASCII character
//   guess_valid  in   strobe qualifying guess
//   ready        out  high while a guess can be accepted
//   letter       out  last evaluated guess (uppercase)
//   indexCorrect out  cumulative revealed mask, bit4 = char0, bit0 = char4
//   correct      out  positions matched by the last guess
//   mistake      out  last evaluated guess was a miss
//   numMistake   out  cumulative misses, saturating at 7
//   game_won     out  all positions revealed
//   game_lost    out  numMistake reached MAX_MISTAKES
module guess_evaluator #(
  parameter int unsigned MAX_MISTAKES = 6
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [39:0] word,
  input  logic        word_load,
  input  logic [7:0]  guess,
  input  logic        guess_valid,
  output logic        ready,
  output logic [7:0]  letter,
  output logic [4:0]  indexCorrect,
  output logic [2:0]  correct,
  output logic        mistake,
  output logic [2:0]  numMistake,
  output logic        game_won,
  output logic        game_lost
);

  typedef enum logic [2:0] {StIdle, StPlay, StEval, StWon, StLost} state_e;

  state_e      state_q, state_d;
  logic [39:0] word_q, word_d;
  logic [7:0]  guess_q, guess_d;
  logic [7:0]  letter_q, letter_d;
  logic [4:0]  index_q, index_d;
  logic [2:0]  correct_q, correct_d;
  logic        mistake_q, mistake_d;
  logic [2:0]  num_mistake_q, num_mistake_d;

  // Guess legality and case folding.
  logic       guess_legal;
  logic [7:0] guess_upper;

  always_comb begin
    guess_legal = 1'b0;
    guess_upper = guess;
    if (guess >= 8'h41 && guess <= 8'h5A) begin
      guess_legal = 1'b1;
    end else if (guess >= 8'h61 && guess <= 8'h7A) begin
      guess_legal = 1'b1;
      guess_upper = guess - 8'h20;
    end
  end

  // match[j] covers word bits [8j+7:8j], which lines up with indexCorrect bit j.
  logic [4:0] match;
  logic [2:0] match_cnt;

  always_comb begin
    match     = '0;
    match_cnt = '0;
    for (int j = 0; j < 5; j++) begin
      match[j]  = (word_q[8*j +: 8] == guess_q);
      match_cnt = match_cnt + 3'(match[j]);
    end
  end

  logic repeat_hit;

`ifdef REPEAT_FILTER_EN
  logic [25:0] used_q, used_d;
  logic [4:0]  letter_idx;

  // guess_q always holds an uppercase letter here, so the index is 0..25.
  assign letter_idx = 5'(guess_q - 8'h41);
  assign repeat_hit = |(used_q & (26'd1 << letter_idx));
`else
  assign repeat_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    guess_d       = guess_q;
    letter_d      = letter_q;
    index_d       = index_q;
    correct_d     = correct_q;
    mistake_d     = mistake_q;
    num_mistake_d = num_mistake_q;
`ifdef REPEAT_FILTER_EN
    used_d        = used_q;
`endif

    if (word_load) begin
      // Restart wins over everything, including a guess pending in EVAL.
      state_d       = StPlay;
      word_d        = word;
      letter_d      = '0;
      index_d       = '0;
      correct_d     = '0;
      mistake_d     = 1'b0;
      num_mistake_d = '0;
`ifdef REPEAT_FILTER_EN
      used_d        = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: ;
        StPlay: begin
          if (guess_valid && guess_legal) begin
            guess_d = guess_upper;
            state_d = StEval;
          end
        end
        StEval: begin
          letter_d = guess_q;
          if (repeat_hit) begin
            correct_d = '0;
            mistake_d = 1'b0;
          end else if (|match) begin
            correct_d = match_cnt;
            index_d   = index_q | match;
            mistake_d = 1'b0;
          end else begin
            correct_d = '0;
            mistake_d = 1'b1;
            if (num_mistake_q != 3'd7) begin
              num_mistake_d = num_mistake_q + 3'd1;
            end
          end
`ifdef REPEAT_FILTER_EN
          used_d = used_q | (26'd1 << letter_idx);
`endif
          if (index_d == 5'b11111) begin
            state_d = StWon;
          end else if (num_mistake_d == 3'(MAX_MISTAKES)) begin
            state_d = StLost;
          end else begin
            state_d = StPlay;
          end
        end
        StWon, StLost: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      state_q       <= StIdle;
      word_q        <= '0;
      guess_q       <= '0;
      letter_q      <= '0;
      index_q       <= '0;
      correct_q     <= '0;
      mistake_q     <= 1'b0;
      num_mistake_q <= '0;
`ifdef REPEAT_FILTER_EN
      used_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      guess_q       <= guess_d;
      letter_q      <= letter_d;
      index_q       <= index_d;
      correct_q     <= correct_d;
      mistake_q     <= mistake_d;
      num_mistake_q <= num_mistake_d;
`ifdef REPEAT_FILTER_EN
      used_q        <= used_d;
`endif
    end
  end

  assign ready        = (state_q == StPlay);
  assign game_won     = (state_q == StWon);
  assign game_lost    = (state_q == StLost);
  assign letter       = letter_q;
  assign indexCorrect = index_q;
  assign correct      = correct_q;
  assign mistake      = mistake_q;
  assign numMistake   = num_mistake_q;

endmodule

// File: tb/tb_guess_evaluator.sv
// Bench for guess_evaluator: directed scenarios with literal expectations plus
// randomized play checked every cycle against a game-level model.
module tb_guess_evaluator;

  localparam int MAXM = 6;
`ifdef REPEAT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam logic [39:0] APPLE = "APPLE";
  localparam logic [39:0] ZWORD = "ZZZZZ";

  logic        tb_clk = 1'b0;
  logic        nRst = 1'b1;
  logic [39:0] word = '0;
  logic        word_load = 1'b0;
  logic [7:0]  guess = '0;
  logic        guess_valid = 1'b0;
  logic        ready;
  logic [7:0]  letter;
  logic [4:0]  indexCorrect;
  logic [2:0]  correct;
  logic        mistake;
  logic [2:0]  numMistake;
  logic        game_won;
  logic        game_lost;

  always #5 tb_clk = ~tb_clk;

  guess_evaluator #(.MAX_MISTAKES(MAXM)) dut (
    .clk          (tb_clk),
    .nRst         (nRst),
    .word         (word),
    .word_load    (word_load),
    .guess        (guess),
    .guess_valid  (guess_valid),
    .ready        (ready),
    .letter       (letter),
    .indexCorrect (indexCorrect),
    .correct      (correct),
    .mistake      (mistake),
    .numMistake   (numMistake),
    .game_won     (game_won),
    .game_lost    (game_lost)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- game-level model ----------------
  bit          m_active = 1'b0;
  bit          m_pend = 1'b0;
  logic [7:0]  m_pch = '0;
  logic [39:0] m_word = '0;
  logic [4:0]  m_mask = '0;
  int          m_correct = 0;
  bit          m_mis = 1'b0;
  int          m_num = 0;
  logic [7:0]  m_letter = '0;
  bit   [25:0] m_used = '0;
  int          m_hits;
  logic [4:0]  m_hitmask;

  function automatic bit is_legal(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61) ? c - 8'h20 : c;
  endfunction

  function automatic bit m_won();
    return m_active && (m_mask == 5'b11111);
  endfunction

  function automatic bit m_lost();
    return m_active && !m_won() && (m_num == MAXM);
  endfunction

  function automatic bit m_ready();
    return m_active && !m_pend && !m_won() && !m_lost();
  endfunction

  always @(posedge tb_clk) begin
    if (nRst) begin
      m_active = 0; m_pend = 0; m_word = '0; m_mask = '0; m_correct = 0;
      m_mis = 0; m_num = 0; m_letter = '0; m_used = '0;
    end else if (word_load) begin
      m_active = 1; m_pend = 0; m_word = word; m_mask = '0; m_correct = 0;
      m_mis = 0; m_num = 0; m_letter = '0; m_used = '0;
    end else if (m_pend) begin
      // Character i of the word sits at bits [39-8i -: 8] and reveals mask bit 4-i.
      m_hits = 0;
      m_hitmask = '0;
      for (int i = 0; i < 5; i++) begin
        if (m_word[39-8*i -: 8] == m_pch) begin
          m_hits++;
          m_hitmask[4-i] = 1'b1;
        end
      end
      m_pend = 0;
      m_letter = m_pch;
      if (FILT && m_used[m_pch - 8'h41]) begin
        m_correct = 0; m_mis = 0;
      end else if (m_hits > 0) begin
        m_correct = m_hits; m_mis = 0; m_mask = m_mask | m_hitmask;
      end else begin
        m_correct = 0; m_mis = 1;
        if (m_num < 7) m_num++;
      end
      m_used[m_pch - 8'h41] = 1'b1;
    end else if (m_ready() && guess_valid && is_legal(guess)) begin
      m_pend = 1;
      m_pch = to_upper(guess);
    end
  end

  always @(negedge tb_clk) begin
    if (chk_en) begin
      chk("ready", 64'(ready), 64'(m_ready()));
      chk("letter", 64'(letter), 64'(m_letter));
      chk("indexCorrect", 64'(indexCorrect), 64'(m_mask));
      chk("correct", 64'(correct), 64'(m_correct));
      chk("mistake", 64'(mistake), 64'(m_mis));
      chk("numMistake", 64'(numMistake), 64'(m_num));
      chk("game_won", 64'(game_won), 64'(m_won()));
      chk("game_lost", 64'(game_lost), 64'(m_lost()));
    end
  end

  // ---------------- stimulus ----------------
  // Drive inputs just after a falling edge, hold through the rising edge.
  task automatic cyc(input logic r, input logic wl, input logic [39:0] w,
                     input logic gv, input logic [7:0] g);
    nRst = r; word_load = wl; word = w; guess_valid = gv; guess = g;
    @(negedge tb_clk);
  endtask

  task automatic do_guess(input logic [7:0] g);
    cyc(1'b0, 1'b0, ZWORD, 1'b1, g);
    cyc(1'b0, 1'b0, ZWORD, 1'b0, 8'h00);
  endtask

  logic [39:0] rw;
  logic [7:0]  rg;
  int          sel;
  string       misses;

  initial begin
    @(negedge tb_clk);
    cyc(1'b1, 1'b0, '0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, APPLE, 1'b1, 8'h41);  // reset beats load and guess
    chk_en = 1'b1;
    chk("rst ready", 64'(ready), 64'd0);
    chk("rst letter", 64'(letter), 64'h00);
    chk("rst outputs", 64'({indexCorrect, correct, mistake, numMistake, game_won, game_lost}), 64'd0);

    // Game 1: hit, miss, illegal, lowercase hit; word input differs after load.
    cyc(1'b0, 1'b1, APPLE, 1'b0, 8'h00);
    chk("load ready", 64'(ready), 64'd1);
    cyc(1'b0, 1'b0, ZWORD, 1'b1, "P");
    chk("eval ready", 64'(ready), 64'd0);
    cyc(1'b0, 1'b0, ZWORD, 1'b0, 8'h00);
    chk("P correct", 64'(correct), 64'd2);
    chk("P mask", 64'(indexCorrect), 64'b01100);
    chk("P mistake", 64'(mistake), 64'd0);
    chk("P letter", 64'(letter), 64'h50);
    do_guess("b");
    chk("b letter", 64'(letter), 64'h42);
    chk("b mistake", 64'(mistake), 64'd1);
    chk("b num", 64'(numMistake), 64'd1);
    chk("b correct", 64'(correct), 64'd0);
    cyc(1'b0, 1'b0, ZWORD, 1'b1, 8'h31);
    chk("'1' ready", 64'(ready), 64'd1);
    chk("'1' letter", 64'(letter), 64'h42);
    do_guess("l");
    chk("l mask", 64'(indexCorrect), 64'b01110);
    chk("l correct", 64'(correct), 64'd1);

    // Repeated miss; ZWORD on the input must not be seen by the latched word.
    cyc(1'b0, 1'b1, APPLE, 1'b0, 8'h00);
    do_guess("Z");
    do_guess("Z");
    chk("ZZ num", 64'(numMistake), FILT ? 64'd1 : 64'd2);
    chk("ZZ mistake", 64'(mistake), FILT ? 64'd0 : 64'd1);

    // Win, then frozen.
    cyc(1'b0, 1'b1, APPLE, 1'b0, 8'h00);
    do_guess("A"); do_guess("P"); do_guess("L"); do_guess("E");
    chk("win mask", 64'(indexCorrect), 64'b11111);
    chk("win flag", 64'(game_won), 64'd1);
    chk("win ready", 64'(ready), 64'd0);
    do_guess("Z"); do_guess("Q");
    chk("win frozen letter", 64'(letter), 64'h45);
    chk("win frozen num", 64'(numMistake), 64'd0);

    // Loss after six distinct misses, then restart.
    cyc(1'b0, 1'b1, APPLE, 1'b0, 8'h00);
    misses = "BCDFGH";
    for (int i = 0; i < 6; i++) do_guess(misses[i]);
    chk("loss num", 64'(numMistake), 64'd6);
    chk("loss flag", 64'(game_lost), 64'd1);
    do_guess("X");
    chk("loss frozen letter", 64'(letter), 64'h48);
    cyc(1'b0, 1'b1, APPLE, 1'b0, 8'h00);
    chk("restart ready", 64'(ready), 64'd1);
    chk("restart outputs",
        64'({letter, indexCorrect, correct, mistake, numMistake, game_won, game_lost}), 64'd0);

    // Reset during EVAL.
    do_guess("A");
    cyc(1'b0, 1'b0, ZWORD, 1'b1, "A");
    cyc(1'b1, 1'b0, ZWORD, 1'b0, 8'h00);
    chk("midrst ready", 64'(ready), 64'd0);
    chk("midrst mask", 64'(indexCorrect), 64'd0);
    cyc(1'b0, 1'b0, ZWORD, 1'b0, 8'h00);
    chk("midrst idle", 64'(ready), 64'd0);

    // word_load with guess_valid, and word_load during EVAL.
    cyc(1'b0, 1'b1, APPLE, 1'b1, "A");
    cyc(1'b0, 1'b0, ZWORD, 1'b0, 8'h00);
    chk("ld+gv ready", 64'(ready), 64'd1);
    chk("ld+gv letter", 64'(letter), 64'h00);
    cyc(1'b0, 1'b0, ZWORD, 1'b1, "E");
    cyc(1'b0, 1'b1, APPLE, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, ZWORD, 1'b0, 8'h00);
    chk("ld-in-eval letter", 64'(letter), 64'h00);
    chk("ld-in-eval mask", 64'(indexCorrect), 64'd0);

    // Randomized play over a small alphabet so hits, wins and losses all occur.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 5; i++) rw[8*i +: 8] = 8'h41 + 8'($urandom_range(0, 7));
      sel = $urandom_range(0, 3);
      if (sel <= 1)      rg = 8'h41 + 8'($urandom_range(0, 9));
      else if (sel == 2) rg = 8'h61 + 8'($urandom_range(0, 9));
      else               rg = 8'($urandom);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0, rw,
          1'($urandom_range(0, 1)), rg);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
